// File: rtl/reverb_m2s_fifo.sv
// reverb_m2s_fifo: Avalon-MM write slave feeding an Avalon-ST source through a register FIFO.
// Optional status port readback enabled by defining M2S_FIFO_STATUS_EN.
`default_nettype none

module reverb_m2s_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              avalonmm_write_slave_address,
    input  logic              avalonmm_write_slave_write,
    input  logic [DATA_W-1:0] avalonmm_write_slave_writedata,
    input  logic              avalonmm_write_slave_read,
    output logic [31:0]       avalonmm_write_slave_readdata,
    output logic              avalonmm_write_slave_waitrequest,
    output logic [DATA_W-1:0] avalonst_source_data,
    output logic              avalonst_source_valid,
    input  logic              avalonst_source_ready
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;
    logic              data_write;
    logic              push;
    logic              pop;

    assign full       = (level == FULL_LEVEL);
    assign empty      = (level == '0);
    assign data_write = !avalonmm_write_slave_address && avalonmm_write_slave_write;
    // A full FIFO stalls the write even when a pop frees a slot this cycle.
    assign push       = data_write && !full;
    assign pop        = avalonst_source_valid && avalonst_source_ready;

    assign avalonmm_write_slave_waitrequest = !reset_n || (data_write && full);
    assign avalonst_source_valid            = !empty;
    assign avalonst_source_data             = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= avalonmm_write_slave_writedata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

`ifdef M2S_FIFO_STATUS_EN
    always_comb begin
        avalonmm_write_slave_readdata = '0;
        if (reset_n && avalonmm_write_slave_read && avalonmm_write_slave_address) begin
            avalonmm_write_slave_readdata[ADDR_W:0] = level;
            avalonmm_write_slave_readdata[30]       = empty;
            avalonmm_write_slave_readdata[31]       = full;
        end
    end
`else
    logic unused_read;
    assign unused_read                   = avalonmm_write_slave_read;
    assign avalonmm_write_slave_readdata = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reverb_m2s_fifo.sv
// tb_reverb_m2s_fifo: scoreboard bench for reverb_m2s_fifo (status checks follow M2S_FIFO_STATUS_EN).
`default_nettype none

module tb_reverb_m2s_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              address = 1'b0;
    logic              write = 1'b0;
    logic [DATA_W-1:0] writedata = '0;
    logic              read = 1'b0;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready = 1'b0;

    logic [DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int popped = 0;
    int max_level = 0;
    logic track_level = 1'b0;

    always #5 clock = ~clock;

    reverb_m2s_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock                            (clock),
        .reset_n                          (reset_n),
        .avalonmm_write_slave_address     (address),
        .avalonmm_write_slave_write       (write),
        .avalonmm_write_slave_writedata   (writedata),
        .avalonmm_write_slave_read        (read),
        .avalonmm_write_slave_readdata    (readdata),
        .avalonmm_write_slave_waitrequest (waitrequest),
        .avalonst_source_data             (data),
        .avalonst_source_valid            (valid),
        .avalonst_source_ready            (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int n);
        logic [31:0] s;
        s = '0;
`ifdef M2S_FIFO_STATUS_EN
        s[ADDR_W:0] = (ADDR_W+1)'(n);
        s[30]       = (n == 0);
        s[31]       = (n == DEPTH);
`endif
        return s;
    endfunction

    // Transfers are observed mid-cycle: valid & ready here means a pop at the next rising edge.
    always @(negedge clock) begin
        if (track_level && int'(dut.level) > max_level) max_level = int'(dut.level);
        if (reset_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {32'h0, data}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                check("stream_data", {32'h0, data}, {32'h0, exp_q.pop_front()});
                popped++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic mm_write(input logic [DATA_W-1:0] d, output int waits);
        waits = 0;
        address = 1'b0;
        write = 1'b1;
        writedata = d;
        @(negedge clock);
        while (waitrequest && waits < 200) begin
            @(negedge clock);
            waits++;
        end
        if (waitrequest) check("write_timeout", 64'(waits), 64'd0);
        else exp_q.push_back(d);
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    task automatic status_check(input string tag, input int n);
        read = 1'b1;
        address = 1'b1;
        #1;
        check(tag, {32'h0, readdata}, {32'h0, exp_status(n)});
        read = 1'b0;
        address = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        check({tag, "_valid"}, {63'h0, valid}, 64'd0);
    endtask

    initial begin
        int w;
        int wsum;

        // Reset state
        read = 1'b1;
        address = 1'b1;
        #3;
        check("rst_valid", {63'h0, valid}, 64'd0);
        check("rst_waitreq", {63'h0, waitrequest}, 64'd1);
        check("rst_readdata", {32'h0, readdata}, 64'd0);
        read = 1'b0;
        address = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        status_check("status_empty", 0);
        check("idle_waitreq", {63'h0, waitrequest}, 64'd0);

        // Two words held with ready low
        mm_write(32'h1111_1111, w);
        check("first_valid", {63'h0, valid}, 64'd1);
        check("first_data", {32'h0, data}, 64'h1111_1111);
        mm_write(32'h2222_2222, w);
        check("held_data", {32'h0, data}, 64'h1111_1111);
        check("level_two", 64'(dut.level), 64'd2);
        status_check("status_two", 2);
        read = 1'b1;
        address = 1'b0;
        #1;
        check("read_addr0", {32'h0, readdata}, 64'd0);
        read = 1'b0;
        // Address-1 write is discarded and never stalls
        address = 1'b1;
        write = 1'b1;
        writedata = 32'hBAD0_BAD0;
        #1;
        check("addr1_waitreq", {63'h0, waitrequest}, 64'd0);
        @(posedge clock);
        #1;
        write = 1'b0;
        address = 1'b0;
        check("addr1_discard", 64'(dut.level), 64'd2);

        // Drain: two consecutive words then valid drops
        ready = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("empty_after_two", {63'h0, valid}, 64'd0);
        ready = 1'b0;

        // Fill to capacity, stall, pulse ready
        for (int i = 0; i < DEPTH; i++) mm_write(DATA_W'(i), w);
        status_check("status_full", DEPTH);
        address = 1'b0;
        write = 1'b1;
        writedata = 32'd64;
        #1;
        check("full_waitreq", {63'h0, waitrequest}, 64'd1);
        fork
            mm_write(32'd64, w);
            begin
                ready = 1'b1;
                @(posedge clock);
                #1;
                ready = 1'b0;
            end
        join
        check("stall_cycles", 64'(w), 64'd1);
        check("full_again", 64'(dut.level), 64'd64);
        ready = 1'b1;
        drain("drain_fill");

        // Back-to-back streaming with ready held
        popped = 0;
        wsum = 0;
        max_level = 0;
        track_level = 1'b1;
        for (int i = 0; i < 200; i++) begin
            mm_write(32'h1000 + DATA_W'(i), w);
            wsum += w;
        end
        drain("drain_stream");
        track_level = 1'b0;
        check("stream_waits", 64'(wsum), 64'd0);
        check("stream_count", 64'(popped), 64'd200);
        check("stream_maxlevel", 64'(max_level <= 1), 64'd1);

        // Asynchronous reset with queued contents
        ready = 1'b0;
        for (int i = 0; i < 10; i++) mm_write(32'h5000 + DATA_W'(i), w);
        status_check("status_ten", 10);
        address = 1'b0;
        write = 1'b1;
        writedata = 32'h7777_7777;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", {63'h0, valid}, 64'd0);
        check("async_waitreq", {63'h0, waitrequest}, 64'd1);
        exp_q.delete();
        @(posedge clock);
        #1;
        check("rst_hold_waitreq", {63'h0, waitrequest}, 64'd1);
        write = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_level", 64'(dut.level), 64'd0);
        check("post_rst_valid", {63'h0, valid}, 64'd0);
        mm_write(32'hABCD_0001, w);
        check("post_rst_first", {32'h0, data}, 64'hABCD_0001);
        ready = 1'b1;
        drain("drain_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
